// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order pipeline (A)
// and a buffered long-latency result stream (B), with starvation and hazard protection.
module wb_port_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            a_valid,
    input  logic [ADDR_W-1:0]               a_addr,
    input  logic [DATA_W-1:0]               a_data,
    output logic                            a_ready,
    input  logic                            b_valid,
    input  logic [ADDR_W-1:0]               b_addr,
    input  logic [DATA_W-1:0]               b_data,
    output logic                            b_ready,
    output logic                            wr_en,
    output logic [ADDR_W-1:0]               wr_addr,
    output logic [DATA_W-1:0]               wr_data,
    output logic                            b_pending,
    output logic [$clog2(FIFO_DEPTH):0]     b_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic fifo_empty;
    logic fifo_full;
    logic addr_match;
    logic grant_a;
    logic grant_b;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

    // Any occupied slot holding A's destination forces B to drain first,
    // so the younger A value is the one that lands last.
    always_comb begin
        addr_match = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (fifo_addr_q[head_q + PTR_W'(i)] == a_addr)) begin
                addr_match = 1'b1;
            end
        end
    end

    always_comb begin
        grant_b = 1'b0;
        if (!fifo_empty) begin
            grant_b = (wait_q == WAIT_W'(MAX_WAIT)) || !a_valid || addr_match;
        end
        grant_a = a_valid && !grant_b;
    end

    assign a_ready = grant_a;
    assign b_ready = !fifo_full;

    // A full FIFO refuses a push even when it pops the same cycle.
    assign push = b_valid && !fifo_full;
    assign pop  = grant_b;

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || grant_b) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Address/data hold their last value when nothing is granted.
    always_comb begin
        wr_en_d   = grant_a || grant_b;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_b) begin
            wr_addr_d = fifo_addr_q[head_q];
            wr_data_d = fifo_data_q[head_q];
        end else if (grant_a) begin
            wr_addr_d = a_addr;
            wr_data_d = a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[tail_q] <= b_addr;
            fifo_data_q[tail_q] <= b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign b_count   = count_q;
    assign b_pending = !fifo_empty;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a table of per-cycle vectors plus a
// hand-written mid-operation reset sequence.
module tb_wb_port_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              b_pending;
    logic [CNT_W-1:0]  b_count;

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(2), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .b_pending(b_pending), .b_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle, and the outputs expected in that same cycle:
    // a_ready/b_ready from this cycle's grant, wr_* from the previous cycle's grant.
    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              bv;
        logic [ADDR_W-1:0] ba;
        logic [DATA_W-1:0] bd;
        logic              e_ar;
        logic              e_br;
        logic              e_en;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int av, input int aa, input int ad,
                       input int bv, input int ba, input int bd,
                       input int ar, input int br, input int en,
                       input int wa, input int wd, input int cnt);
        vec_t v;
        v.av = 1'(av);  v.aa = ADDR_W'(aa); v.ad = DATA_W'(ad);
        v.bv = 1'(bv);  v.ba = ADDR_W'(ba); v.bd = DATA_W'(bd);
        v.e_ar = 1'(ar); v.e_br = 1'(br); v.e_en = 1'(en);
        v.e_addr = ADDR_W'(wa); v.e_data = DATA_W'(wd); v.e_cnt = CNT_W'(cnt);
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();

        // Reset state
        @(negedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_b_count", b_count, 0);
        check("rst_b_pending", b_pending, 0);
        rst = 1'b0;
        #1;
        check("rst_b_ready", b_ready, 1);

        //   av aa ad   bv ba bd   ar br en wa  wd   cnt
        // A only
        add(1, 3, 100, 0, 0, 0,   1, 1, 0, 0,  0,   0);
        add(1, 3, 100, 0, 0, 0,   1, 1, 1, 3,  100, 0);
        add(1, 3, 100, 0, 0, 0,   1, 1, 1, 3,  100, 0);
        add(0, 0, 0,   0, 0, 0,   0, 1, 1, 3,  100, 0);
        // Fill two B entries behind A traffic, then idle drain in order
        add(1, 1, 20,  1, 5, 7,   1, 1, 0, 3,  100, 0);
        add(1, 1, 21,  1, 6, 9,   1, 1, 1, 1,  20,  1);
        add(0, 0, 0,   0, 0, 0,   0, 0, 1, 1,  21,  2);
        add(0, 0, 0,   0, 0, 0,   0, 1, 1, 5,  7,   1);
        add(0, 0, 0,   0, 0, 0,   0, 1, 1, 6,  9,   0);
        // Starvation: r2=11 forced out after MAX_WAIT cycles of A
        add(1, 7, 30,  1, 2, 11,  1, 1, 0, 6,  9,   0);
        add(1, 8, 31,  0, 0, 0,   1, 1, 1, 7,  30,  1);
        add(1, 9, 32,  0, 0, 0,   1, 1, 1, 8,  31,  1);
        add(1, 10, 33, 0, 0, 0,   1, 1, 1, 9,  32,  1);
        add(1, 11, 34, 0, 0, 0,   1, 1, 1, 10, 33,  1);
        add(1, 12, 35, 0, 0, 0,   0, 1, 1, 11, 34,  1);
        add(1, 12, 35, 0, 0, 0,   1, 1, 1, 2,  11,  0);
        // Collision on r4: older B value written before A's
        add(0, 0, 0,   1, 4, 1,   0, 1, 1, 12, 35,  0);
        add(1, 4, 2,   0, 0, 0,   0, 1, 0, 12, 35,  1);
        add(1, 4, 2,   0, 0, 0,   1, 1, 1, 4,  1,   0);
        add(0, 0, 0,   0, 0, 0,   0, 1, 1, 4,  2,   0);
        // Full FIFO with third entry held until a forced pop frees a slot
        add(1, 13, 40, 1, 8, 50,  1, 1, 0, 4,  2,   0);
        add(1, 13, 41, 1, 9, 51,  1, 1, 1, 13, 40,  1);
        add(1, 13, 42, 1, 10, 52, 1, 0, 1, 13, 41,  2);
        add(1, 13, 43, 1, 10, 52, 1, 0, 1, 13, 42,  2);
        add(1, 13, 44, 1, 10, 52, 1, 0, 1, 13, 43,  2);
        add(1, 13, 45, 1, 10, 52, 0, 0, 1, 13, 44,  2);
        add(1, 13, 45, 1, 10, 52, 1, 1, 1, 8,  50,  1);
        add(0, 0, 0,   0, 0, 0,   0, 0, 1, 13, 45,  2);
        add(0, 0, 0,   0, 0, 0,   0, 1, 1, 9,  51,  1);
        add(0, 0, 0,   0, 0, 0,   0, 1, 1, 10, 52,  0);

        foreach (vq[i]) begin
            @(negedge clk);
            a_valid = vq[i].av; a_addr = vq[i].aa; a_data = vq[i].ad;
            b_valid = vq[i].bv; b_addr = vq[i].ba; b_data = vq[i].bd;
            #1;
            check($sformatf("v%0d_a_ready", i), a_ready, vq[i].e_ar);
            check($sformatf("v%0d_b_ready", i), b_ready, vq[i].e_br);
            check($sformatf("v%0d_wr_en", i), wr_en, vq[i].e_en);
            check($sformatf("v%0d_wr_addr", i), wr_addr, vq[i].e_addr);
            check($sformatf("v%0d_wr_data", i), wr_data, vq[i].e_data);
            check($sformatf("v%0d_b_count", i), b_count, vq[i].e_cnt);
            check($sformatf("v%0d_b_pending", i), b_pending, (vq[i].e_cnt != 0) ? 1 : 0);
        end

        // Mid-operation reset with two B entries queued and a write in flight
        @(negedge clk);
        a_valid = 1'b1; a_addr = 4'd13; a_data = 16'd60;
        b_valid = 1'b1; b_addr = 4'd14; b_data = 16'd70;
        @(negedge clk);
        a_data = 16'd61; b_addr = 4'd15; b_data = 16'd71;
        @(negedge clk);
        #1;
        check("pre_rst_b_count", b_count, 2);
        check("pre_rst_wr_en", wr_en, 1);
        drive_idle();
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_b_count", b_count, 0);
        check("mid_rst_b_pending", b_pending, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_b_ready", b_ready, 1);
        check("post_rst_a_ready", a_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_rst_idle%0d_wr_en", k), wr_en, 0);
            check($sformatf("post_rst_idle%0d_b_count", k), b_count, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
